// File: rtl/encryptor_if.sv
// Bus interface for the encryptor core: the block inputs (plaintext, key)
// and the registered results (ciphertext, done).
// The controller side uses the master modport and the core uses the slave modport.
interface encryptor_if;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         done;

    modport master (
        output plaintext,
        output key,
        input  ciphertext,
        input  done
    );

    modport slave (
        input  plaintext,
        input  key,
        output ciphertext,
        output done
    );
endinterface

// File: rtl/encryptor.sv
// encryptor: iterative AES-128 encryption core, one cipher round per clock.
// The round keys are expanded on the fly, so only one round key is stored at a time.
// Byte 0 of the FIPS-197 input order sits in bits [127:120]. The state is column-major,
// so byte i holds row (i % 4) and column (i / 4).
// Optional feature macro: ENCRYPTOR_AUTORESTART_EN. When it is defined, DONE lasts one
// cycle and the core then returns to LOAD to take the next block.
module encryptor (
    input  logic       clk,
    input  logic       rst,
    encryptor_if.slave bus
);

    typedef enum logic [1:0] {
        S_RESET,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] aesState_q, aesState_d;
    logic [127:0] roundKey_q, roundKey_d;
    logic [127:0] ciphertext_q, ciphertext_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [127:0] subState;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] nextKey;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotWord, subWord, keyTemp;
    logic [31:0]  n0, n1, n2, n3;

    // Multiplication in GF(2^8), reduced by the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box: the multiplicative inverse (x^254, with 0 mapping to 0) followed by the AES affine map.
    function automatic logic [7:0] sBox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        sq  = gfMul(x, x);
        inv = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
        return b ^ 8'h63;
    endfunction

    // Multiplication by 2 in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Select the round constant for the round that is currently executing.
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Key schedule step: derive the next round key from the current one (uses 4 S-boxes).
    always_comb begin
        w0      = roundKey_q[127:96];
        w1      = roundKey_q[95:64];
        w2      = roundKey_q[63:32];
        w3      = roundKey_q[31:0];
        rotWord = {w3[23:0], w3[31:24]};
        subWord = {sBox(rotWord[31:24]), sBox(rotWord[23:16]),
                   sBox(rotWord[15:8]),  sBox(rotWord[7:0])};
        keyTemp = subWord ^ {rcon, 24'h000000};
        n0      = w0 ^ keyTemp;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        nextKey = {n0, n1, n2, n3};
    end

    // Round datapath: SubBytes over 16 S-boxes, then ShiftRows, then MixColumns.
    always_comb begin
        subState = '0;
        shifted  = '0;
        mixed    = '0;
        for (int i = 0; i < 16; i++) begin
            subState[127 - 8*i -: 8] = sBox(aesState_q[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(r + 4*c) -: 8] = subState[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = shifted[127 - 8*(4*c)     -: 8];
            a1 = shifted[127 - 8*(4*c + 1) -: 8];
            a2 = shifted[127 - 8*(4*c + 2) -: 8];
            a3 = shifted[127 - 8*(4*c + 3) -: 8];
            mixed[127 - 8*(4*c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mixed[127 - 8*(4*c + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mixed[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mixed[127 - 8*(4*c + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // Control: sequence LOAD, ten rounds, then DONE. The last round skips MixColumns and writes the result.
    always_comb begin
        state_d      = state_q;
        aesState_d   = aesState_q;
        roundKey_d   = roundKey_q;
        round_d      = round_q;
        ciphertext_d = ciphertext_q;
        done_d       = done_q;
        case (state_q)
            S_RESET, S_LOAD: begin
                aesState_d = bus.plaintext ^ bus.key;
                roundKey_d = bus.key;
                round_d    = 4'd1;
                state_d    = S_ROUND;
            end
            S_ROUND: begin
                roundKey_d = nextKey;
                if (round_q == 4'd10) begin
                    ciphertext_d = shifted ^ nextKey;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    aesState_d = mixed ^ nextKey;
                    round_d    = round_q + 4'd1;
                end
            end
            S_DONE: begin
`ifdef ENCRYPTOR_AUTORESTART_EN
                done_d  = 1'b0;
                state_d = S_LOAD;
`else
                state_d = S_DONE;
`endif
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State registers; a low rst on a clock edge clears everything and re-arms LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            aesState_q   <= '0;
            roundKey_q   <= '0;
            round_q      <= 4'd0;
            ciphertext_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            aesState_q   <= aesState_d;
            roundKey_q   <= roundKey_d;
            round_q      <= round_d;
            ciphertext_q <= ciphertext_d;
            done_q       <= done_d;
        end
    end

    assign bus.ciphertext = ciphertext_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_encryptor.sv
// Testbench for encryptor. It holds a byte-level AES-128 reference model with a
// table-driven S-box and a fully expanded key schedule, plus a cycle-level tracker
// of the expected ciphertext/done. Directed vectors are checked against FIPS-197 literals.
module tb_encryptor;

    logic clk;
    logic rst;
    encryptor_if bus ();

    int testsRun;
    int failures;

    logic [7:0] sboxTable [256];

    encryptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Multiplication by 2 in GF(2^8).
    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Build the S-box table by walking the generator 3 and its inverse together.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxTable[p] = x ^ 8'h63;
        end
        sboxTable[0] = 8'h63;
    endtask

    // Reference AES-128: expand all 44 key words first, then run the ten rounds on a byte array.
    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sboxTable[tmp[31:24]], sboxTable[tmp[23:16]],
                       sboxTable[tmp[15:8]], sboxTable[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = mul2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sboxTable[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = s[r + 4*((c + r) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = mul2(t[4*c]) ^ mul2(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ mul2(t[4*c+1]) ^ mul2(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul2(t[4*c+2]) ^ mul2(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = mul2(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ mul2(t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Cycle-level expectation: tracks edges since LOAD and publishes the result on the 11th edge.
    localparam int PH_LOAD = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_HOLD = 2;
    int           phase;
    int           edgeCount;
    logic         modelValid;
    logic [127:0] capPt, capKey;
    logic [127:0] expCt;
    logic         expDone;

    initial begin
        modelValid = 1'b0;
        phase      = PH_LOAD;
        edgeCount  = 0;
        expCt      = '0;
        expDone    = 1'b0;
    end

    // Advance the expectation on every rising edge using the inputs seen at that edge.
    always @(posedge clk) begin
        if (!rst) begin
            expCt      = '0;
            expDone    = 1'b0;
            phase      = PH_LOAD;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (phase == PH_LOAD) begin
                capPt     = bus.plaintext;
                capKey    = bus.key;
                edgeCount = 0;
                phase     = PH_RUN;
            end else if (phase == PH_RUN) begin
                edgeCount++;
                if (edgeCount == 10) begin
                    expCt   = aesEncrypt(capPt, capKey);
                    expDone = 1'b1;
                    phase   = PH_HOLD;
                end
            end else begin
`ifdef ENCRYPTOR_AUTORESTART_EN
                expDone = 1'b0;
                phase   = PH_LOAD;
`endif
            end
        end
    end

    // Compare the DUT against the expectation on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (modelValid) begin
            testsRun++;
            if (bus.ciphertext !== expCt) begin
                failures++;
                $display("[TB] FAIL cycleCiphertext: got %h want %h", bus.ciphertext, expCt);
            end
            testsRun++;
            if (bus.done !== expDone) begin
                failures++;
                $display("[TB] FAIL cycleDone: got %b want %b", bus.done, expDone);
            end
        end
    end

    // Drive one set of inputs and let exactly one rising edge consume them.
    task automatic applyStimulus(input logic r, input logic [127:0] p, input logic [127:0] k);
        rst           = r;
        bus.plaintext = p;
        bus.key       = k;
        @(posedge clk);
        #1;
    endtask

    // Check both outputs against hand-computed literals.
    task automatic checkOutput(input string name, input logic [127:0] wantCt, input logic wantDone);
        testsRun++;
        if (bus.ciphertext !== wantCt) begin
            failures++;
            $display("[TB] FAIL %s ciphertext: got %h want %h", name, bus.ciphertext, wantCt);
        end
        testsRun++;
        if (bus.done !== wantDone) begin
            failures++;
            $display("[TB] FAIL %s done: got %b want %b", name, bus.done, wantDone);
        end
    endtask

    // Check a reference-model result against a published vector.
    task automatic checkModel(input string name, input logic [127:0] got, input logic [127:0] want);
        testsRun++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
`ifdef ENCRYPTOR_AUTORESTART_EN
        int firstDone;
        int secondDone;
        int doneEdges;
`endif
        testsRun      = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        buildSbox();

        checkModel("modelAppendixB", aesEncrypt(PT_B, KEY_B), CT_B);
        checkModel("modelAppendixC1", aesEncrypt(PT_C, KEY_C), CT_C);

        // Reset held for two edges with arbitrary inputs.
        applyStimulus(1'b0, 128'd1407, 128'd25);
        checkOutput("reset0", '0, 1'b0);
        applyStimulus(1'b0, 128'd1407, 128'd25);
        checkOutput("reset1", '0, 1'b0);

        // Appendix B vector: done stays low until edge 10.
        for (int e = 0; e < 10; e++) begin
            applyStimulus(1'b1, PT_B, KEY_B);
            checkOutput("vecBbusy", '0, 1'b0);
        end
        applyStimulus(1'b1, PT_B, KEY_B);
        checkOutput("vecBdone", CT_B, 1'b1);

`ifndef ENCRYPTOR_AUTORESTART_EN
        // Result must hold for 20 cycles while the inputs wander.
        for (int e = 0; e < 20; e++) begin
            applyStimulus(1'b1, {4{$urandom()}}, {4{$urandom()}});
            checkOutput("hold", CT_B, 1'b1);
        end
`endif

        // Appendix C.1 vector, with the inputs changed from edge 3 onward.
        applyStimulus(1'b0, '0, '0);
        checkOutput("reset2", '0, 1'b0);
        for (int e = 0; e <= 10; e++) begin
            if (e < 3) applyStimulus(1'b1, PT_C, KEY_C);
            else       applyStimulus(1'b1, 128'd285, 128'd1293);
        end
        checkOutput("vecCinputsIgnored", CT_C, 1'b1);

        // Abort at edge 5, then a clean restart.
        applyStimulus(1'b0, '0, '0);
        for (int e = 0; e < 5; e++) applyStimulus(1'b1, PT_B, KEY_B);
        applyStimulus(1'b0, PT_B, KEY_B);
        checkOutput("abort", '0, 1'b0);
        for (int e = 0; e <= 10; e++) applyStimulus(1'b1, PT_B, KEY_B);
        checkOutput("restart", CT_B, 1'b1);

`ifdef ENCRYPTOR_AUTORESTART_EN
        // Back-to-back blocks: done pulses once per block, and the results arrive 12 edges apart.
        applyStimulus(1'b0, '0, '0);
        firstDone  = -1;
        secondDone = -1;
        doneEdges  = 0;
        for (int e = 0; e < 24; e++) begin
            if (e <= 10) applyStimulus(1'b1, PT_B, KEY_B);
            else         applyStimulus(1'b1, PT_C, KEY_C);
            if (bus.done === 1'b1) begin
                doneEdges++;
                if (firstDone < 0) firstDone = e;
                else               secondDone = e;
            end
            if (e == 10) checkOutput("autoFirst", CT_B, 1'b1);
            if (e == 11) checkOutput("autoPulseEnd", CT_B, 1'b0);
            if (e == 22) checkOutput("autoSecond", CT_C, 1'b1);
            if (e == 23) checkOutput("autoHeld", CT_C, 1'b0);
        end
        testsRun++;
        if (secondDone - firstDone != 12) begin
            failures++;
            $display("[TB] FAIL autoSpacing: got %0d want 12", secondDone - firstDone);
        end
        testsRun++;
        if (doneEdges != 2) begin
            failures++;
            $display("[TB] FAIL autoPulses: got %0d want 2", doneEdges);
        end
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
